dcache_tag_ram_nway: RTL and testbench

Parametrised N-way tag store for the data cache, successor to the single-way 256x21 tag RAM. Holds tag plus valid bit per way per set, with write-first semantics on a shared clock. Adds a registered lookup with per-way tag compare, a hit/way result, and a hardware invalidate sweep after reset or on request. Sits between the dcache core lookup pipeline and its refill/evict logic.

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_tag_ram_nway_if.sv | 48 ++++
 rtl/dcache_tag_way_ram.sv | 32 +++
 rtl/dcache_tag_ram_nway.sv | 128 ++++++++++++
 tb/tb_dcache_tag_ram_nway.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared dcache tag-store defaults and sweep FSM encoding.
// Optional DCACHE_TAG_PARITY_EN adds one even-parity bit per stored entry.
package dcache_pkg;

  localparam int DCACHE_TAG_W = 20;
  localparam int DCACHE_SETS  = 256;
  localparam int DCACHE_WAYS  = 2;

`ifdef DCACHE_TAG_PARITY_EN
  localparam int DCACHE_PAR_W = 1;
`else
  localparam int DCACHE_PAR_W = 0;
`endif

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/dcache_tag_ram_nway_if.sv
// Lookup/write/flush bus of the N-way tag store; parity_err_o exists only
// with DCACHE_TAG_PARITY_EN.
interface dcache_tag_ram_nway_if
  import dcache_pkg::*;
#(
  parameter int WAYS    = DCACHE_WAYS,
  parameter int TAG_W   = DCACHE_TAG_W,
  parameter int INDEX_W = $clog2(DCACHE_SETS),
  parameter int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
);
  logic                  rd_req_i;
  logic [INDEX_W-1:0]    rd_idx_i;
  logic [TAG_W-1:0]      cmp_tag_i;
  logic                  wr_i;
  logic [INDEX_W-1:0]    wr_idx_i;
  logic [WAY_W-1:0]      wr_way_i;
  logic [TAG_W-1:0]      wr_tag_i;
  logic                  wr_valid_i;
  logic                  flush_i;
  logic                  ready_o;
  logic                  rd_valid_o;
  logic [WAYS*TAG_W-1:0] tag_o;
  logic [WAYS-1:0]       valid_o;
  logic                  hit_o;
  logic [WAY_W-1:0]      hit_way_o;
`ifdef DCACHE_TAG_PARITY_EN
  logic                  parity_err_o;
`endif

  modport master (
    output rd_req_i, rd_idx_i, cmp_tag_i, wr_i, wr_idx_i, wr_way_i,
           wr_tag_i, wr_valid_i, flush_i,
`ifdef DCACHE_TAG_PARITY_EN
    input  parity_err_o,
`endif
    input  ready_o, rd_valid_o, tag_o, valid_o, hit_o, hit_way_o
  );

  modport slave (
    input  rd_req_i, rd_idx_i, cmp_tag_i, wr_i, wr_idx_i, wr_way_i,
           wr_tag_i, wr_valid_i, flush_i,
`ifdef DCACHE_TAG_PARITY_EN
    output parity_err_o,
`endif
    output ready_o, rd_valid_o, tag_o, valid_o, hit_o, hit_way_o
  );

endinterface

// File: rtl/dcache_tag_way_ram.sv
// One way of the tag store: DEPTH x WIDTH, one write and one registered read
// port; a same-address write in the read cycle is forwarded (write-first).
module dcache_tag_way_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 21,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          rdata <= '0;
    else if (re) begin
      if (we && (waddr == raddr)) rdata <= wdata;
      else                        rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dcache_tag_ram_nway.sv
// N-way dcache tag store with registered lookup, per-way compare and an
// invalidate sweep after reset or flush. Optional: DCACHE_TAG_PARITY_EN.
//
// state    | meaning
// ST_SWEEP | clearing set sweep_cnt_q in every way; bus requests ignored
// ST_IDLE  | ready; lookups, writes and flush requests accepted
module dcache_tag_ram_nway
  import dcache_pkg::*;
#(
  parameter int WAYS  = DCACHE_WAYS,
  parameter int DEPTH = DCACHE_SETS,
  parameter int TAG_W = DCACHE_TAG_W
) (
  input logic                 clk_i,
  input logic                 rst_i,
  dcache_tag_ram_nway_if.slave bus
);

  localparam int INDEX_W = $clog2(DEPTH);
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int ENT_W   = TAG_W + 1 + DCACHE_PAR_W;

  sweep_state_e       state_q, state_d;
  logic [INDEX_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic               sweep;
  logic               rd_valid_q;
  logic               rd_en;
  logic               ready;
  logic [INDEX_W-1:0] wr_addr;
  logic [ENT_W-1:0]   wr_ent;
  logic [ENT_W-1:0]   rd_ent [WAYS];
  logic [WAYS-1:0]    par_err;
  logic [WAYS-1:0]    way_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    sweep       = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        sweep       = 1'b1;
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        if (sweep_cnt_q == INDEX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.flush_i) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = '0;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  assign ready   = (state_q == ST_IDLE);
  assign rd_en   = bus.rd_req_i & ready;
  assign wr_addr = sweep ? sweep_cnt_q : bus.wr_idx_i;

  // The sweep writes an all-zero entry, which is also parity-consistent.
  always_comb begin
    wr_ent = '0;
    if (!sweep) begin
`ifdef DCACHE_TAG_PARITY_EN
      wr_ent = {^{bus.wr_valid_i, bus.wr_tag_i}, bus.wr_valid_i, bus.wr_tag_i};
`else
      wr_ent = {bus.wr_valid_i, bus.wr_tag_i};
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_valid_q <= 1'b0;
    else       rd_valid_q <= rd_en;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_we;
    assign way_we = !rst_i &&
                    (sweep || (bus.wr_i && ready && (bus.wr_way_i == WAY_W'(w))));

    dcache_tag_way_ram #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_ram (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (way_we),
      .waddr (wr_addr),
      .wdata (wr_ent),
      .re    (rd_en),
      .raddr (bus.rd_idx_i),
      .rdata (rd_ent[w])
    );

    assign bus.tag_o[w*TAG_W +: TAG_W] = rd_ent[w][TAG_W-1:0];
    assign bus.valid_o[w]              = rd_ent[w][TAG_W];
`ifdef DCACHE_TAG_PARITY_EN
    assign par_err[w] = ^rd_ent[w];
`else
    assign par_err[w] = 1'b0;
`endif
    assign way_hit[w] = rd_ent[w][TAG_W] && !par_err[w] &&
                        (rd_ent[w][TAG_W-1:0] == bus.cmp_tag_i);
  end

  // Descending scan so the lowest hitting way wins.
  always_comb begin
    bus.hit_way_o = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) bus.hit_way_o = WAY_W'(w);
    end
  end

  assign bus.hit_o      = |way_hit;
  assign bus.ready_o    = ready;
  assign bus.rd_valid_o = rd_valid_q;
`ifdef DCACHE_TAG_PARITY_EN
  assign bus.parity_err_o = rd_valid_q & (|par_err);
`endif

endmodule

// File: tb/tb_dcache_tag_ram_nway.sv
// Directed bench for dcache_tag_ram_nway (WAYS=2, DEPTH=256, TAG_W=20).
module tb_dcache_tag_ram_nway;
  import dcache_pkg::*;

  localparam int WAYS    = 2;
  localparam int DEPTH   = 256;
  localparam int TAG_W   = 20;
  localparam int INDEX_W = 8;
  localparam int WAY_W   = 1;

  logic clk_i = 1'b0;
  logic rst_i;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  dcache_tag_ram_nway_if #(.WAYS(WAYS), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAY_W(WAY_W)) bus ();

  dcache_tag_ram_nway #(.WAYS(WAYS), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  wr_idx;
    logic        wr_way;
    logic [19:0] wr_tag;
    logic        wr_valid;
    logic        rd;
    logic [7:0]  rd_idx;
    logic [19:0] cmp;
    logic        e_rdv;
    logic [1:0]  e_valid;
    logic [19:0] e_tag0;
    logic [19:0] e_tag1;
    logic        e_hit;
    logic        e_way;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req_i   = 1'b0;
    bus.rd_idx_i   = '0;
    bus.cmp_tag_i  = '0;
    bus.wr_i       = 1'b0;
    bus.wr_idx_i   = '0;
    bus.wr_way_i   = '0;
    bus.wr_tag_i   = '0;
    bus.wr_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
  endtask

  task automatic write_entry(input logic [7:0] idx, input logic way, input logic [19:0] tag);
    bus.wr_i = 1'b1; bus.wr_idx_i = idx; bus.wr_way_i = way;
    bus.wr_tag_i = tag; bus.wr_valid_i = 1'b1;
    do_cycle();
    bus.wr_i = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] idx, input logic [19:0] cmp);
    bus.rd_req_i = 1'b1; bus.rd_idx_i = idx;
    do_cycle();
    bus.rd_req_i = 1'b0; bus.cmp_tag_i = cmp;
    #1;
  endtask

  // Samples ready_o once per cycle until it rises; returns low-cycle count.
  task automatic count_sweep(output int n, output int rdv_seen, input bit poke);
    n = 0;
    rdv_seen = 0;
    while (!bus.ready_o && n < 1000) begin
      if (bus.rd_valid_o) rdv_seen++;
      n++;
      bus.flush_i = poke && (n == 50);
      bus.rd_req_i = poke;
      bus.rd_idx_i = 8'h01;
      bus.wr_i = poke;
      bus.wr_idx_i = 8'h06; bus.wr_way_i = 1'b0;
      bus.wr_tag_i = 20'h5A5A5; bus.wr_valid_i = 1'b1;
      do_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    int n, rdv;

    vec[0] = '{1'b1, 8'h12, 1'b1, 20'hABCDE, 1'b1, 1'b0, 8'h00, 20'h00000, 1'b0, 2'b00, 20'h00000, 20'h00000, 1'b0, 1'b0};
    vec[1] = '{1'b0, 8'h00, 1'b0, 20'h00000, 1'b0, 1'b1, 8'h12, 20'hABCDE, 1'b1, 2'b10, 20'h00000, 20'hABCDE, 1'b1, 1'b1};
    vec[2] = '{1'b0, 8'h00, 1'b0, 20'h00000, 1'b0, 1'b0, 8'h00, 20'hABCDF, 1'b0, 2'b10, 20'h00000, 20'hABCDE, 1'b0, 1'b0};
    vec[3] = '{1'b1, 8'h40, 1'b0, 20'h11111, 1'b1, 1'b1, 8'h40, 20'h11111, 1'b1, 2'b01, 20'h11111, 20'h00000, 1'b1, 1'b0};
    vec[4] = '{1'b1, 8'h40, 1'b1, 20'h11111, 1'b1, 1'b0, 8'h00, 20'h11111, 1'b0, 2'b01, 20'h11111, 20'h00000, 1'b1, 1'b0};
    vec[5] = '{1'b0, 8'h00, 1'b0, 20'h00000, 1'b0, 1'b1, 8'h40, 20'h11111, 1'b1, 2'b11, 20'h11111, 20'h11111, 1'b1, 1'b0};
    vec[6] = '{1'b1, 8'h40, 1'b0, 20'h11111, 1'b0, 1'b1, 8'h40, 20'h11111, 1'b1, 2'b10, 20'h11111, 20'h11111, 1'b1, 1'b1};
    vec[7] = '{1'b0, 8'h00, 1'b0, 20'h00000, 1'b0, 1'b1, 8'h12, 20'h00000, 1'b1, 2'b10, 20'h00000, 20'hABCDE, 1'b0, 1'b0};
    vec[8] = '{1'b1, 8'h12, 1'b0, 20'h00000, 1'b1, 1'b0, 8'h00, 20'h00000, 1'b0, 2'b10, 20'h00000, 20'hABCDE, 1'b0, 1'b0};
    vec[9] = '{1'b0, 8'h00, 1'b0, 20'h00000, 1'b0, 1'b1, 8'h12, 20'h00000, 1'b1, 2'b11, 20'h00000, 20'hABCDE, 1'b1, 1'b0};

    idle_inputs();
    rst_i = 1'b1;
    do_cycle();
    rst_i = 1'b0;
    check("rst_ready",    64'(bus.ready_o),    64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid_o), 64'd0);
    check("rst_valid",    64'(bus.valid_o),    64'd0);
    check("rst_tag",      64'(bus.tag_o),      64'd0);

    count_sweep(n, rdv, 1'b0);
    check("reset_sweep_len", 64'(n), 64'd256);

    lookup(8'h77, 20'h00000);
    check("post_sweep_rdv",   64'(bus.rd_valid_o), 64'd1);
    check("post_sweep_valid", 64'(bus.valid_o),    64'd0);
    check("post_sweep_hit",   64'(bus.hit_o),      64'd0);

    foreach (vec[i]) begin
      bus.wr_i = vec[i].wr; bus.wr_idx_i = vec[i].wr_idx; bus.wr_way_i = vec[i].wr_way;
      bus.wr_tag_i = vec[i].wr_tag; bus.wr_valid_i = vec[i].wr_valid;
      bus.rd_req_i = vec[i].rd; bus.rd_idx_i = vec[i].rd_idx;
      do_cycle();
      bus.wr_i = 1'b0; bus.rd_req_i = 1'b0;
      bus.cmp_tag_i = vec[i].cmp;
      #1;
      check($sformatf("v%0d_rd_valid", i), 64'(bus.rd_valid_o),       64'(vec[i].e_rdv));
      check($sformatf("v%0d_valid", i),    64'(bus.valid_o),          64'(vec[i].e_valid));
      check($sformatf("v%0d_tag0", i),     64'(bus.tag_o[19:0]),      64'(vec[i].e_tag0));
      check($sformatf("v%0d_tag1", i),     64'(bus.tag_o[39:20]),     64'(vec[i].e_tag1));
      check($sformatf("v%0d_hit", i),      64'(bus.hit_o),            64'(vec[i].e_hit));
      check($sformatf("v%0d_hit_way", i),  64'(bus.hit_way_o),        64'(vec[i].e_way));
    end

    // Fill sets 0..3, then flush in the same cycle as a write to set 5.
    for (int s = 0; s < 4; s++) begin
      write_entry(8'(s), 1'b0, 20'(s + 1));
      write_entry(8'(s), 1'b1, 20'(s + 16));
    end
    lookup(8'h02, 20'h00003);
    check("fill_valid", 64'(bus.valid_o), 64'd3);
    check("fill_hit",   64'(bus.hit_o),   64'd1);
    bus.flush_i = 1'b1;
    bus.wr_i = 1'b1; bus.wr_idx_i = 8'h05; bus.wr_way_i = 1'b1;
    bus.wr_tag_i = 20'h77777; bus.wr_valid_i = 1'b1;
    do_cycle();
    idle_inputs();
    count_sweep(n, rdv, 1'b1);
    check("flush_sweep_len", 64'(n),   64'd256);
    check("flush_rd_ignored", 64'(rdv), 64'd0);
    foreach (vec[i]) begin
      logic [7:0] idx;
      idx = (i < 4) ? 8'(i) : (i == 4) ? 8'h05 : (i == 5) ? 8'h06 : (i == 6) ? 8'h12 : 8'h40;
      lookup(idx, 20'h00000);
      check($sformatf("flushed_valid_%0h", idx), 64'(bus.valid_o), 64'd0);
    end

    // Reset 100 cycles into a sweep restarts it from set 0.
    write_entry(8'h33, 1'b0, 20'h0F0F0);
    rst_i = 1'b1;
    do_cycle();
    rst_i = 1'b0;
    repeat (99) do_cycle();
    check("mid_sweep_ready", 64'(bus.ready_o), 64'd0);
    rst_i = 1'b1;
    do_cycle();
    rst_i = 1'b0;
    count_sweep(n, rdv, 1'b0);
    check("restart_sweep_len", 64'(n), 64'd256);
    lookup(8'h33, 20'h0F0F0);
    check("restart_valid", 64'(bus.valid_o), 64'd0);
    check("restart_hit",   64'(bus.hit_o),   64'd0);

`ifdef DCACHE_TAG_PARITY_EN
    write_entry(8'h20, 1'b0, 20'h12345);
    lookup(8'h20, 20'h12345);
    check("par_clean_err", 64'(bus.parity_err_o), 64'd0);
    check("par_clean_hit", 64'(bus.hit_o),        64'd1);
    dut.g_way[0].u_ram.mem[32] = dut.g_way[0].u_ram.mem[32] ^ 22'h1;
    lookup(8'h20, 20'h12344);
    check("par_flip_err", 64'(bus.parity_err_o), 64'd1);
    check("par_flip_hit", 64'(bus.hit_o),        64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
